// File: rtl/apb_wdog_pkg.sv
// Shared constants and types for the APB watchdog responder.
package apb_wdog_pkg;

  // Register word indices (paddr[11:2])
  localparam logic [9:0] IDX_LOAD    = 10'h000;
  localparam logic [9:0] IDX_VALUE   = 10'h001;
  localparam logic [9:0] IDX_CONTROL = 10'h002;
  localparam logic [9:0] IDX_INTCLR  = 10'h003;
  localparam logic [9:0] IDX_RIS     = 10'h004;
  localparam logic [9:0] IDX_MIS     = 10'h005;
  localparam logic [9:0] IDX_LOCK    = 10'h300;
  localparam logic [9:0] IDX_PID3    = 10'h3FB;

  localparam logic [31:0] UNLOCK_KEY = 32'h1ACC_E551;

  // CONTROL bit positions
  localparam int unsigned CTRL_INTEN = 0;
  localparam int unsigned CTRL_RESEN = 1;
  localparam int unsigned CTRL_W     = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT,
    DONE
  } apb_phase_e;

endpackage

// File: rtl/apb_wdog_counter.sv
// Watchdog down-counter with RIS and sticky reset-request state.
module apb_wdog_counter
  import apb_wdog_pkg::*;
#(
  parameter logic [31:0] LOAD_RST = 32'hFFFF_FFFF
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        tick_i,
  input  logic        load_we_i,
  input  logic [31:0] load_data_i,
  input  logic        reload_i,
  input  logic [31:0] reload_data_i,
  input  logic        resen_i,
  output logic [31:0] value_o,
  output logic        ris_o,
  output logic        wdogres_o,
  output logic        timeout_o
);

  logic [31:0] value_q, value_d;
  logic        ris_q, ris_d;
  logic        res_q, res_d;
  logic        timeout;

  // Next-state: APB load beats reload, reload (INTCLR) beats timeout.
  always_comb begin
    timeout = tick_i && (value_q == '0);
    value_d = value_q;
    ris_d   = ris_q;
    res_d   = res_q;
    if (tick_i) begin
      value_d = timeout ? reload_data_i : value_q - 32'd1;
    end
    if (timeout) begin
      if (!ris_q) begin
        ris_d = 1'b1;
      end else if (resen_i && !reload_i) begin
        res_d = 1'b1;
      end
    end
    if (reload_i) begin
      ris_d   = 1'b0;
      value_d = reload_data_i;
    end
    if (load_we_i) begin
      value_d = load_data_i;
    end
  end

  // Counter state registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      value_q <= LOAD_RST;
      ris_q   <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ris_q   <= ris_d;
      res_q   <= res_d;
    end
  end

  assign value_o   = value_q;
  assign ris_o     = ris_q;
  assign wdogres_o = res_q;
  assign timeout_o = timeout;

endmodule

// File: rtl/apb_wdog_responder.sv
// APB3 completer for the watchdog register set: decode, wait states, LOCK, CONTROL.
module apb_wdog_responder
  import apb_wdog_pkg::*;
#(
  parameter logic [31:0] LOAD_RST    = 32'hFFFF_FFFF,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [11:2] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  input  logic        wdogclken,
  input  logic [3:0]  ecorevnum,
  output logic        wdogint,
  output logic        wdogres
);

  localparam logic [1:0] WS_LAST = 2'(WAIT_STATES);

  apb_phase_e        phase_q, phase_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic [31:0]       load_q, load_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              locked_q, locked_d;
  logic              wdogint_q, wdogint_d;

  logic              access, wait_done, wr_en, rd_en;
  logic              load_we, intclr_we;
  logic [31:0]       rdata;
  logic [31:0]       value;
  logic              ris, timeout;

  // APB phase register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      phase_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      phase_q    <= phase_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // APB next phase; a completed access held past DONE is not re-executed
  always_comb begin
    phase_d    = phase_q;
    wait_cnt_d = '0;
    if (!psel) begin
      phase_d = IDLE;
    end else if (!penable) begin
      phase_d = SETUP;
    end else if (phase_q == DONE || wait_done) begin
      phase_d = DONE;
    end else begin
      phase_d    = WAIT;
      wait_cnt_d = wait_cnt_q + 2'd1;
    end
  end

  // APB outputs; reset gates the combinational bus outputs immediately
  always_comb begin
    access    = psel && penable && (phase_q != DONE);
    wait_done = (wait_cnt_q == WS_LAST);
    wr_en     = access && wait_done && pwrite;
    rd_en     = access && wait_done && !pwrite;
    pready    = !presetn || !access || wait_done;
    prdata    = (presetn && rd_en) ? rdata : '0;
  end

  // Read mux (pre-update register values)
  always_comb begin
    rdata = '0;
    case (paddr)
      IDX_LOAD:    rdata = load_q;
      IDX_VALUE:   rdata = value;
      IDX_CONTROL: rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
      IDX_RIS:     rdata = {31'd0, ris};
      IDX_MIS:     rdata = {31'd0, ris & ctrl_q[CTRL_INTEN]};
      IDX_LOCK:    rdata = {31'd0, locked_q};
      IDX_PID3:    rdata = {24'd0, ecorevnum, 4'd0};
      default:     rdata = '0;
    endcase
  end

  // Register writes and registered next-state MIS
  always_comb begin
    load_d    = load_q;
    ctrl_d    = ctrl_q;
    locked_d  = locked_q;
    load_we   = 1'b0;
    intclr_we = 1'b0;
    if (wr_en) begin
      case (paddr)
        IDX_LOAD: begin
          load_we = !locked_q;
          if (!locked_q) load_d = pwdata;
        end
        IDX_CONTROL: begin
          if (!locked_q) ctrl_d = pwdata[CTRL_W-1:0];
        end
        IDX_INTCLR: intclr_we = !locked_q;
        IDX_LOCK:   locked_d  = (pwdata != UNLOCK_KEY);
        default: ;
      endcase
    end
    wdogint_d = (ris || timeout) && !intclr_we && ctrl_d[CTRL_INTEN];
  end

  // Top-level register state
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      load_q    <= LOAD_RST;
      ctrl_q    <= '0;
      locked_q  <= 1'b0;
      wdogint_q <= 1'b0;
    end else begin
      load_q    <= load_d;
      ctrl_q    <= ctrl_d;
      locked_q  <= locked_d;
      wdogint_q <= wdogint_d;
    end
  end

  apb_wdog_counter #(
    .LOAD_RST (LOAD_RST)
  ) u_counter (
    .pclk          (pclk),
    .presetn       (presetn),
    .tick_i        (wdogclken && ctrl_q[CTRL_INTEN]),
    .load_we_i     (load_we),
    .load_data_i   (pwdata),
    .reload_i      (intclr_we),
    .reload_data_i (load_q),
    .resen_i       (ctrl_q[CTRL_RESEN]),
    .value_o       (value),
    .ris_o         (ris),
    .wdogres_o     (wdogres),
    .timeout_o     (timeout)
  );

  assign wdogint = wdogint_q;

endmodule

// File: tb/tb_apb_wdog_responder.sv
// Directed bench for apb_wdog_responder (zero and two wait-state instances).
module tb_apb_wdog_responder;
  import apb_wdog_pkg::*;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel0, penable0, psel1, penable1;
  logic        pwrite;
  logic [11:2] paddr;
  logic [31:0] pwdata;
  logic        wdogclken;
  logic [3:0]  ecorevnum;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1;
  logic        wdogint0, wdogint1, wdogres0, wdogres1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_wdog_responder dut0 (
    .pclk (pclk), .presetn (presetn), .psel (psel0), .penable (penable0),
    .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .prdata (prdata0),
    .pready (pready0), .wdogclken (wdogclken), .ecorevnum (ecorevnum),
    .wdogint (wdogint0), .wdogres (wdogres0)
  );

  apb_wdog_responder #(.WAIT_STATES(2)) dut1 (
    .pclk (pclk), .presetn (presetn), .psel (psel1), .penable (penable1),
    .pwrite (pwrite), .paddr (paddr), .pwdata (pwdata), .prdata (prdata1),
    .pready (pready1), .wdogclken (wdogclken), .ecorevnum (ecorevnum),
    .wdogint (wdogint1), .wdogres (wdogres1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input int unsigned inst);
    return (inst == 0) ? pready0 : pready1;
  endfunction

  task automatic set_sel(input int unsigned inst, input logic s, input logic e);
    if (inst == 0) begin psel0 = s; penable0 = e; end
    else begin psel1 = s; penable1 = e; end
  endtask

  // Starts and ends 1ns after a rising edge
  task automatic apb_xfer(input int unsigned inst, input logic wr, input logic [9:0] idx,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int unsigned waits);
    pwrite = wr; paddr = idx; pwdata = wdata;
    set_sel(inst, 1'b1, 1'b0);
    @(posedge pclk); #1;
    set_sel(inst, 1'b1, 1'b1);
    waits = 0;
    @(negedge pclk);
    while (!rdy(inst) && waits < 8) begin
      waits++;
      @(negedge pclk);
    end
    check_eq("pready_completion", {31'd0, rdy(inst)}, 32'd1);
    rdata = (inst == 0) ? prdata0 : prdata1;
    @(posedge pclk); #1;
    set_sel(inst, 1'b0, 1'b0);
  endtask

  task automatic apb_wr(input int unsigned inst, input logic [9:0] idx, input logic [31:0] d);
    logic [31:0] dummy;
    int unsigned w;
    apb_xfer(inst, 1'b1, idx, d, dummy, w);
  endtask

  task automatic rd_check(input int unsigned inst, input string tag, input logic [9:0] idx,
                          input logic [31:0] exp);
    logic [31:0] d;
    int unsigned w;
    apb_xfer(inst, 1'b0, idx, '0, d, w);
    check_eq(tag, d, exp);
  endtask

  task automatic tick_n(input int unsigned n);
    wdogclken = 1'b1;
    repeat (n) @(posedge pclk);
    #1;
    wdogclken = 1'b0;
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] d;
    int unsigned w;
    presetn = 1'b1; psel0 = 0; penable0 = 0; psel1 = 0; penable1 = 0;
    pwrite = 0; paddr = '0; pwdata = '0; wdogclken = 0; ecorevnum = 4'h5;
    #2 presetn = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    check_eq("rst_prdata",  prdata0, 32'h0);
    check_eq("rst_pready",  {31'd0, pready0}, 32'd1);
    check_eq("rst_wdogint", {31'd0, wdogint0}, 32'd0);
    check_eq("rst_wdogres", {31'd0, wdogres0}, 32'd0);
    presetn = 1'b1;

    rd_check(0, "rst_load",  IDX_LOAD,    32'hFFFF_FFFF);
    rd_check(0, "rst_value", IDX_VALUE,   32'hFFFF_FFFF);
    rd_check(0, "rst_ctrl",  IDX_CONTROL, 32'h0);
    rd_check(0, "rst_lock",  IDX_LOCK,    32'h0);
    rd_check(0, "pid3",      IDX_PID3,    32'h50);

    // LOAD=3: first timeout on tick 4, second on tick 8
    apb_wr(0, IDX_LOAD, 32'd3);
    rd_check(0, "value_after_load", IDX_VALUE, 32'd3);
    apb_wr(0, IDX_CONTROL, 32'd3);
    rd_check(0, "ctrl_rw", IDX_CONTROL, 32'd3);
    wdogclken = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check_eq("wdogint_before_timeout", {31'd0, wdogint0}, 32'd0);
    @(posedge pclk); #1;
    check_eq("wdogint_at_timeout", {31'd0, wdogint0}, 32'd1);
    check_eq("wdogres_first_timeout", {31'd0, wdogres0}, 32'd0);
    repeat (3) @(posedge pclk);
    #1;
    check_eq("wdogres_before_second", {31'd0, wdogres0}, 32'd0);
    @(posedge pclk); #1;
    check_eq("wdogres_second_timeout", {31'd0, wdogres0}, 32'd1);
    wdogclken = 1'b0;
    rd_check(0, "value_reloaded", IDX_VALUE, 32'd3);

    // Lock blocks LOAD and INTCLR; unlock restores writes
    apb_wr(0, IDX_LOCK, 32'd0);
    apb_wr(0, IDX_LOAD, 32'd8);
    apb_wr(0, IDX_INTCLR, 32'd0);
    rd_check(0, "locked_load", IDX_LOAD, 32'd3);
    rd_check(0, "locked_ris",  IDX_RIS,  32'd1);
    rd_check(0, "locked_mis",  IDX_MIS,  32'd1);
    rd_check(0, "lock_read",   IDX_LOCK, 32'd1);
    apb_wr(0, IDX_LOCK, UNLOCK_KEY);
    apb_wr(0, IDX_LOAD, 32'd8);
    rd_check(0, "unlocked_load", IDX_LOAD, 32'd8);
    rd_check(0, "unlock_read",   IDX_LOCK, 32'd0);

    // INTCLR commit coincides with a timeout while RIS=1, RESEN=1
    do_reset();
    check_eq("wdogres_cleared_by_reset", {31'd0, wdogres0}, 32'd0);
    apb_wr(0, IDX_LOAD, 32'd2);
    apb_wr(0, IDX_CONTROL, 32'd3);
    tick_n(3);
    check_eq("wdogint_first", {31'd0, wdogint0}, 32'd1);
    tick_n(2);
    rd_check(0, "value_zero", IDX_VALUE, 32'd0);
    pwrite = 1'b1; paddr = IDX_INTCLR; pwdata = 32'hDEAD_BEEF;
    psel0 = 1'b1; penable0 = 1'b0;
    @(posedge pclk); #1;
    penable0 = 1'b1; wdogclken = 1'b1;
    @(posedge pclk); #1;
    psel0 = 1'b0; penable0 = 1'b0; wdogclken = 1'b0;
    check_eq("clr_vs_timeout_wdogres", {31'd0, wdogres0}, 32'd0);
    check_eq("clr_vs_timeout_wdogint", {31'd0, wdogint0}, 32'd0);
    rd_check(0, "clr_vs_timeout_ris",   IDX_RIS,   32'd0);
    rd_check(0, "clr_vs_timeout_value", IDX_VALUE, 32'd2);

    // Two wait states, then an aborted write
    apb_xfer(1, 1'b1, IDX_LOAD, 32'h55, d, w);
    check_eq("ws2_write_waits", w, 32'd2);
    apb_xfer(1, 1'b0, IDX_LOAD, '0, d, w);
    check_eq("ws2_read_waits", w, 32'd2);
    check_eq("ws2_read_data", d, 32'h55);
    pwrite = 1'b1; paddr = IDX_LOAD; pwdata = 32'h99;
    psel1 = 1'b1; penable1 = 1'b0;
    @(posedge pclk); #1;
    penable1 = 1'b1;
    @(posedge pclk); #1;
    check_eq("ws2_abort_pready", {31'd0, pready1}, 32'd0);
    psel1 = 1'b0; penable1 = 1'b0;
    @(posedge pclk); #1;
    rd_check(1, "ws2_abort_load", IDX_LOAD, 32'h55);

    // Reset during a write access phase
    pwrite = 1'b1; paddr = IDX_LOAD; pwdata = 32'h1234;
    psel1 = 1'b1; penable1 = 1'b0;
    @(posedge pclk); #1;
    penable1 = 1'b1;
    #2;
    check_eq("midrst_pready_before", {31'd0, pready1}, 32'd0);
    presetn = 1'b0;
    #1;
    check_eq("midrst_pready",  {31'd0, pready1}, 32'd1);
    check_eq("midrst_prdata",  prdata1, 32'h0);
    check_eq("midrst_wdogint", {31'd0, wdogint1}, 32'd0);
    check_eq("midrst_wdogres", {31'd0, wdogres1}, 32'd0);
    psel1 = 1'b0; penable1 = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    rd_check(1, "midrst_load",  IDX_LOAD,  32'hFFFF_FFFF);
    rd_check(1, "midrst_value", IDX_VALUE, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
